// File: rtl/shift_ctrl.sv
// shift_ctrl: parallel-to-serial frame controller driving an external shift register.
// Optional even-parity bit after each frame when SHIFT_CTRL_PARITY_EN is defined.
module shift_ctrl #(
  parameter int NBITS      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_dir,
  input  logic             abort,
  output logic             sr_load,
  output logic [NBITS-1:0] sr_data,
  output logic             sr_shift,
  output logic             sr_dir,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(NBITS + 1);
`ifdef SHIFT_CTRL_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, PARITY, FIN, GAP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, FIN, GAP} state_t;
`endif
  state_t state, state_n;
  logic [NBITS-1:0] shadow, shadow_n, word_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] gap, gap_n;
  logic dir_n, ser_n, xfer, last;
`ifdef SHIFT_CTRL_PARITY_EN
  logic par, par_n;
`endif
  assign in_ready = (state == IDLE) & ~abort & ~rst;
  assign xfer = in_valid & in_ready;
  assign last = cnt == CW'(NBITS - 1);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = xfer ? LOAD : IDLE;
      LOAD:    state_n = SHIFT;
`ifdef SHIFT_CTRL_PARITY_EN
      SHIFT:   state_n = last ? PARITY : SHIFT;
      PARITY:  state_n = FIN;
`else
      SHIFT:   state_n = last ? FIN : SHIFT;
`endif
      FIN:     state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     state_n = (gap == 4'(GAP_CYCLES - 1)) ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) state_n = IDLE;
  end
  // Shadow holds the bits still to be sent; its edge bit is the next serial bit.
  always_comb begin
    word_n   = xfer ? in_data : sr_data;
    dir_n    = xfer ? in_dir : sr_dir;
    shadow_n = xfer ? in_data : (state == SHIFT) ? (sr_dir ? shadow >> 1 : shadow << 1) : shadow;
    cnt_n    = (state == SHIFT) ? cnt + 1'b1 : '0;
    gap_n    = (state == GAP) ? gap + 1'b1 : '0;
`ifdef SHIFT_CTRL_PARITY_EN
    par_n    = xfer ? ^in_data : par;
    ser_n    = (state_n == SHIFT) ? (dir_n ? shadow_n[0] : shadow_n[NBITS-1]) :
               (state_n == PARITY) ? par_n : 1'b0;
`else
    ser_n    = (state_n == SHIFT) ? (dir_n ? shadow_n[0] : shadow_n[NBITS-1]) : 1'b0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      sr_data   <= '0;
      sr_dir    <= 1'b0;
      cnt       <= '0;
      gap       <= '0;
      sr_load   <= 1'b0;
      sr_shift  <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SHIFT_CTRL_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shadow    <= shadow_n;
      sr_data   <= word_n;
      sr_dir    <= dir_n;
      cnt       <= cnt_n;
      gap       <= gap_n;
      sr_load   <= state_n == LOAD;
      sr_shift  <= state_n == SHIFT;
      ser_out   <= ser_n;
      busy      <= state_n != IDLE;
      done      <= state_n == FIN;
`ifdef SHIFT_CTRL_PARITY_EN
      par       <= par_n;
      ser_valid <= (state_n == SHIFT) || (state_n == PARITY);
`else
      ser_valid <= state_n == SHIFT;
`endif
    end
  end
endmodule

// File: tb/tb_shift_ctrl.sv
// tb_shift_ctrl: randomized scoreboard bench for shift_ctrl plus directed reset/abort/back-to-back cases.
module tb_shift_ctrl;
  localparam int N = 4;
  localparam int GAP = 1;
`ifdef SHIFT_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = N + P;
  logic clk = 0, rst = 1, in_valid = 0, in_dir = 0, abort = 0;
  logic [N-1:0] in_data = '0;
  logic in_ready, sr_load, sr_shift, sr_dir, ser_out, ser_valid, busy, done;
  logic [N-1:0] sr_data;
  logic v1 = 0, dir1 = 0, ab1 = 0;
  logic [N-1:0] d1 = '0;
  logic r1, l1, sh1, sd1, so1, sv1, b1, dn1;
  logic [N-1:0] dd1;
  int vectors = 0, miscompares = 0, cyc = 0, next_idle = 0, bi = 0;
  logic exp_ready = 0, exp_busy = 0, mon_en = 0, active = 0;
  typedef struct {
    int k;
    logic [N-1:0] word;
    logic dir;
    logic [FL-1:0] bits;
  } frame_t;
  frame_t q[$];
  frame_t cur;

  shift_ctrl #(.NBITS(N), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dir(in_dir), .abort(abort), .sr_load(sr_load), .sr_data(sr_data), .sr_shift(sr_shift),
    .sr_dir(sr_dir), .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done));

  shift_ctrl #(.NBITS(N), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1),
    .in_dir(dir1), .abort(ab1), .sr_load(l1), .sr_data(dd1), .sr_shift(sh1),
    .sr_dir(sd1), .ser_out(so1), .ser_valid(sv1), .busy(b1), .done(dn1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Serial order straight from the frame rules: MSB-first or LSB-first, then even parity.
  function automatic logic [FL-1:0] expect_bits(logic [N-1:0] w, logic d);
    logic [FL-1:0] b = '0;
    for (int i = 0; i < N; i++) b[i] = d ? w[i] : w[N-1-i];
    if (P == 1) b[FL-1] = ^w;
    return b;
  endfunction

  task automatic drive(logic v, logic [N-1:0] w, logic d, logic ab);
    frame_t f;
    in_valid = v; in_data = w; in_dir = d; abort = ab;
    exp_busy = cyc < next_idle;
    exp_ready = (cyc >= next_idle) && !ab;
    if (v && exp_ready) begin
      f.k = cyc; f.word = w; f.dir = d; f.bits = expect_bits(w, d);
      q.push_back(f);
      next_idle = cyc + 3 + FL + GAP;
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk); #1;
      drive(1'b0, N'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic send(logic [N-1:0] w, logic d);
    int t = 0;
    do begin
      @(posedge clk); #1;
      drive(1'b1, w, d, 1'b0);
      t++;
    end while (!exp_ready && t < 100);
    check("send_accept", exp_ready, 1);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || cyc < next_idle || active) && t < 100) begin
      idle(1);
      t++;
    end
    idle(1);
    check("drain_queue", q.size(), 0);
  endtask

  task automatic resync();
    q.delete();
    active = 0;
    next_idle = 0;
    @(posedge clk); #1;
    drive(1'b0, '0, 1'b0, 1'b0);
    mon_en = 1;
  endtask

  always @(negedge clk) if (mon_en) begin
    check("in_ready", in_ready, exp_ready);
    check("busy", busy, exp_busy);
    check("load_excl", sr_load & (sr_shift | ser_valid), 0);
    if (sr_load) begin
      check("load_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        cur = q.pop_front();
        active = 1;
        bi = 0;
        check("load_cycle", cyc, cur.k + 1);
        check("sr_data", sr_data, cur.word);
        check("sr_dir_load", sr_dir, cur.dir);
      end
    end
    if (ser_valid) begin
      if (active && bi < FL) begin
        check("ser_out", ser_out, cur.bits[bi]);
        check("sr_shift", sr_shift, bi < N);
        check("sr_dir_shift", sr_dir, cur.dir);
        bi++;
      end else check("stray_ser_valid", ser_valid, 0);
    end else begin
      check("ser_out_quiet", ser_out, 0);
      check("sr_shift_quiet", sr_shift, 0);
    end
    if (done) begin
      check("done_cycle", cyc, cur.k + 2 + FL);
      check("done_bits", bi, FL);
      active = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outs", {sr_load, sr_shift, sr_dir, ser_out, ser_valid, busy, done, sr_data}, 0);
    check("reset_ready", in_ready, 0);
    @(posedge clk); #1; rst = 0;
    resync();
    send(4'b0010, 1'b0);
    drain();
    send(4'b0111, 1'b1);
    drain();
    repeat (400) begin
      @(posedge clk); #1;
      drive(1'($urandom), N'($urandom), 1'($urandom), (cyc >= next_idle) && ($urandom_range(5, 0) == 0));
    end
    drain();
    // reset for three edges in the middle of a frame
    send(4'b1011, 1'b1);
    idle(3);
    @(posedge clk); #1;
    mon_en = 0; rst = 1; in_valid = 1;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_outs", {sr_load, sr_shift, sr_dir, ser_out, ser_valid, busy, done, sr_data}, 0);
      check("rst_ready", in_ready, 0);
    end
    rst = 0; in_valid = 0;
    repeat (8) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
    end
    resync();
    drain();
    // abort on the second serial bit, then a new word on the following idle cycle
    @(posedge clk); #1;
    mon_en = 0; in_valid = 1; in_data = 4'b1100; in_dir = 0; abort = 0;
    @(posedge clk); #1; in_valid = 0;
    @(negedge clk); check("ab_load", sr_load, 1);
    @(posedge clk); #1;
    @(posedge clk); #1; abort = 1;
    @(negedge clk);
    check("ab_shift_outs", {sr_shift, ser_valid, ser_out}, 3'b111);
    check("ab_done_abort_cycle", done, 0);
    @(posedge clk); #1; abort = 0; in_valid = 1; in_data = 4'b0101; in_dir = 1;
    @(negedge clk);
    check("ab_idle_busy", busy, 0);
    check("ab_idle_done", done, 0);
    check("ab_idle_ready", in_ready, 1);
    @(posedge clk); #1; in_valid = 0;
    @(negedge clk);
    check("ab_new_load", sr_load, 1);
    check("ab_new_data", sr_data, 4'b0101);
    check("ab_new_dir", sr_dir, 1);
    repeat (FL + GAP + 4) @(posedge clk);
    resync();
    // zero-gap instance: held in_valid, back-to-back frames
    @(negedge clk); v1 = 1; d1 = 4'b1001; dir1 = 0;
    t = 0;
    while (!dn1 && t < 50) begin @(negedge clk); t++; end
    check("g0_done_seen", dn1, 1);
    @(negedge clk);
    check("g0_idle_ready", r1, 1);
    check("g0_idle_busy", b1, 0);
    @(negedge clk);
    check("g0_second_load", l1, 1);
    t = 0;
    while (!dn1 && t < 50) begin @(negedge clk); t++; end
    check("g0_done2_seen", dn1, 1);
    ab1 = 1;
    @(negedge clk);
    check("g0_abort_ready", r1, 0);
    @(negedge clk);
    check("g0_abort_noload", l1, 0);
    check("g0_abort_busy", b1, 0);
    v1 = 0; ab1 = 0;
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
